// File: rtl/framebuffer_stream_pkg.sv
// Shared types and width helpers for the framebuffer stream responder.
package framebuffer_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_t;

  localparam int DEF_PIXELS_PER_BEAT = 2;
  localparam int DEF_SUB_PIXELS      = 4;
  localparam int DEF_SUB_PIXEL_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH      = 32;
  localparam int DEF_RD_FIFO_DEPTH   = 4;

  function automatic int stream_width(input int pixels, input int sub_pixels,
                                      input int sub_pixel_width);
    return pixels * sub_pixels * sub_pixel_width;
  endfunction

  function automatic int beat_bytes_lg(input int width_bits);
    return $clog2(width_bits / 8);
  endfunction

endpackage

// File: rtl/framebuffer_stream_responder_fifo.sv
// Read-return buffer: synchronous FIFO with a registered count.
module stream_read_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     aclk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] store_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && ((count_q != CNT_FULL) || pop_ok);
  assign head    = store_q[rd_ptr_q];
  assign count   = count_q;

  // Data storage; contents are don't-care while empty, so no reset is needed.
  always_ff @(posedge aclk) begin
    if (push_ok) store_q[wr_ptr_q] <= push_data;
  end

  // Pointers and occupancy; reset flushes the buffer.
  always_ff @(posedge aclk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/framebuffer_stream_responder.sv
// Memory-side responder: one address request at a time, writes stream beats
// into the word memory port or streams memory words back out.
//
//   state    | meaning
//   ST_IDLE  | ready for a request; zero-beat requests are accepted and dropped
//   ST_WRITE | s_axis beats pass straight through to the memory write port
//   ST_READ  | credit-limited memory reads, returns buffered and streamed out
module framebuffer_stream_responder
  import framebuffer_stream_pkg::*;
#(
  parameter int NUMBER_OF_PIXELS_PER_BEAT = DEF_PIXELS_PER_BEAT,
  parameter int NUMBER_OF_SUB_PIXELS      = DEF_SUB_PIXELS,
  parameter int SUB_PIXEL_WIDTH           = DEF_SUB_PIXEL_WIDTH,
  parameter int ADDR_WIDTH                = DEF_ADDR_WIDTH,
  parameter int RD_FIFO_DEPTH             = DEF_RD_FIFO_DEPTH,
  localparam int STREAM_WIDTH  = stream_width(NUMBER_OF_PIXELS_PER_BEAT,
                                              NUMBER_OF_SUB_PIXELS, SUB_PIXEL_WIDTH),
  localparam int STRB_WIDTH    = NUMBER_OF_PIXELS_PER_BEAT * NUMBER_OF_SUB_PIXELS,
  localparam int BEAT_BYTES_LG = beat_bytes_lg(STREAM_WIDTH),
  localparam int WADDR_WIDTH   = ADDR_WIDTH - BEAT_BYTES_LG
) (
  input  logic                    aclk,
  input  logic                    reset,
  input  logic                    s_avalid,
  output logic                    s_aready,
  input  logic [ADDR_WIDTH-1:0]   s_aaddr,
  input  logic [ADDR_WIDTH-1:0]   s_abeats,
  input  logic                    s_arnw,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  input  logic [STREAM_WIDTH-1:0] s_axis_tdata,
  input  logic [STRB_WIDTH-1:0]   s_axis_tstrb,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic [STREAM_WIDTH-1:0] m_axis_tdata,
  output logic                    mem_req,
  output logic                    mem_we,
  input  logic                    mem_gnt,
  output logic [WADDR_WIDTH-1:0]  mem_addr,
  output logic [STREAM_WIDTH-1:0] mem_wdata,
  output logic [STRB_WIDTH-1:0]   mem_wstrb,
  input  logic                    mem_rvalid,
  input  logic [STREAM_WIDTH-1:0] mem_rdata,
  output logic                    err_tlast
);

  localparam int CNT_WIDTH = $clog2(RD_FIFO_DEPTH) + 1;
  localparam logic [ADDR_WIDTH-1:0]  BEAT_ONE    = ADDR_WIDTH'(1);
  localparam logic [WADDR_WIDTH-1:0] WORD_ONE    = WADDR_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]   CNT_ONE     = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH:0]     DEPTH_LIMIT = (CNT_WIDTH + 1)'(RD_FIFO_DEPTH);

  state_t                  state_q, state_d;
  logic [WADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]   issue_left_q, issue_left_d;
  logic [ADDR_WIDTH-1:0]   beats_left_q, beats_left_d;
  logic [CNT_WIDTH-1:0]    outstanding_q;
  logic [CNT_WIDTH-1:0]    fifo_count;
  logic [STREAM_WIDTH-1:0] fifo_head;
  logic                    fifo_empty, fifo_push, fifo_pop;
  logic                    rd_issue, credit_ok, last_beat;
  logic                    err_d, err_tlast_q;
  logic                    unused_addr_lsbs;

  // Start addresses are beat aligned; the byte offset bits carry no information.
  assign unused_addr_lsbs = ^s_aaddr[BEAT_BYTES_LG-1:0];

  assign last_beat = (beats_left_q == BEAT_ONE);
  // Outstanding reads plus buffered words may never exceed the buffer depth,
  // which is what makes an unconditional push on mem_rvalid safe.
  assign credit_ok = ({1'b0, outstanding_q} + {1'b0, fifo_count}) < DEPTH_LIMIT;
  assign fifo_push = mem_rvalid && (outstanding_q != '0);
  assign fifo_pop  = (state_q == ST_READ) && m_axis_tvalid && m_axis_tready;

  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = fifo_head;
  assign m_axis_tlast  = !fifo_empty && last_beat;
  assign mem_addr      = addr_q;
  assign mem_wdata     = s_axis_tdata;
  assign mem_wstrb     = s_axis_tstrb;
  assign err_tlast     = err_tlast_q;

  // Next-state, counter updates and handshake outputs.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    issue_left_d  = issue_left_q;
    beats_left_d  = beats_left_q;
    s_aready      = 1'b0;
    s_axis_tready = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    rd_issue      = 1'b0;
    err_d         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        s_aready = !reset;
        if (s_avalid && !reset) begin
          addr_d       = s_aaddr[ADDR_WIDTH-1:BEAT_BYTES_LG];
          issue_left_d = s_abeats;
          beats_left_d = s_abeats;
          if (s_abeats != '0) state_d = s_arnw ? ST_WRITE : ST_READ;
        end
      end
      ST_WRITE: begin
        mem_req       = s_axis_tvalid;
        mem_we        = 1'b1;
        s_axis_tready = mem_gnt;
        if (s_axis_tvalid && mem_gnt) begin
          addr_d       = addr_q + WORD_ONE;
          beats_left_d = beats_left_q - BEAT_ONE;
          // The beat count terminates the burst; tlast is only checked.
          err_d        = (s_axis_tlast != last_beat);
          if (last_beat) state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        mem_req = (issue_left_q != '0) && credit_ok;
        if (mem_req && mem_gnt) begin
          rd_issue     = 1'b1;
          addr_d       = addr_q + WORD_ONE;
          issue_left_d = issue_left_q - BEAT_ONE;
        end
        if (fifo_pop) begin
          beats_left_d = beats_left_q - BEAT_ONE;
          if (last_beat) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and request bookkeeping registers.
  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      issue_left_q <= '0;
      beats_left_q <= '0;
      err_tlast_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      issue_left_q <= issue_left_d;
      beats_left_q <= beats_left_d;
      err_tlast_q  <= err_d;
    end
  end

  // Reads issued but not yet returned; returns arriving with none pending are stale.
  always_ff @(posedge aclk) begin
    if (reset) begin
      outstanding_q <= '0;
    end else begin
      case ({rd_issue, fifo_push})
        2'b10:   outstanding_q <= outstanding_q + CNT_ONE;
        2'b01:   outstanding_q <= outstanding_q - CNT_ONE;
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

  stream_read_fifo #(
    .WIDTH (STREAM_WIDTH),
    .DEPTH (RD_FIFO_DEPTH)
  ) u_rd_fifo (
    .aclk      (aclk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (mem_rdata),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule
